// File: rtl/mesh_result_collector_if.sv
// Bundle of the mesh-side result lanes and the row-stream handshake
// toward writeback. The slave modport is the collector's view; the
// master modport is the environment that drives the mesh lanes and
// consumes the deskewed rows.
interface mesh_result_collector_if #(
   parameter int WIDTH = 16
);
   logic                    in_start;
   logic signed [WIDTH-1:0] in_c_0;
   logic signed [WIDTH-1:0] in_c_1;
   logic signed [WIDTH-1:0] in_c_2;
   logic signed [WIDTH-1:0] in_c_3;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] out_c_0;
   logic signed [WIDTH-1:0] out_c_1;
   logic signed [WIDTH-1:0] out_c_2;
   logic signed [WIDTH-1:0] out_c_3;
   logic [1:0]              out_row;
   logic                    out_last;
   logic                    busy;
   logic                    overrun;

   modport slave (
      input  in_start, in_c_0, in_c_1, in_c_2, in_c_3, out_ready,
      output out_valid, out_c_0, out_c_1, out_c_2, out_c_3,
             out_row, out_last, busy, overrun
   );

   modport master (
      output in_start, in_c_0, in_c_1, in_c_2, in_c_3, out_ready,
      input  out_valid, out_c_0, out_c_1, out_c_2, out_c_3,
             out_row, out_last, busy, overrun
   );
endinterface

// File: rtl/mesh_result_collector.sv
// Collects one skewed 4x4 result tile from the mesh output lanes,
// removes the per-lane one-cycle skew and streams the tile out as four
// aligned rows over valid/ready.
// Optional feature: define RESULT_RELU_EN to clamp negative elements to
// zero at the output mux (the tile buffer keeps the raw values).
module mesh_result_collector #(
   parameter int WIDTH     = 16,
   parameter int START_LAT = 1
) (
   input  logic                          clock,
   input  logic                          reset_n,
   mesh_result_collector_if.slave        io
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_CAPTURE = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] lat_cnt_q, lat_cnt_d;
   logic [2:0] cap_cnt_q, cap_cnt_d;
   logic [1:0] row_idx_q, row_idx_d;
   logic       overrun_q;
   logic       cap_en;
   logic       drain;

   // Lane samples are registered once; the capture stage writes the
   // buffer from this register, so the sample taken at edge
   // E0+START_LAT+j+k lands in the tile one edge later.
   logic signed [WIDTH-1:0] lane_p0 [4];
   logic signed [WIDTH-1:0] tile_q  [4][4];

   function automatic logic signed [WIDTH-1:0] relu_clamp(
      input logic signed [WIDTH-1:0] x
   );
`ifdef RESULT_RELU_EN
      return x[WIDTH-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   // State, counters and the sticky overrun flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         lat_cnt_q <= '0;
         cap_cnt_q <= '0;
         row_idx_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         cap_cnt_q <= cap_cnt_d;
         row_idx_q <= row_idx_d;
         if (io.in_start && (state_q != S_IDLE))
            overrun_q <= 1'b1;
      end
   end

   // Next-state logic: start wait, 7-cycle skewed capture, 4-row drain.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      cap_cnt_d = cap_cnt_q;
      row_idx_d = row_idx_q;
      cap_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (io.in_start) begin
               state_d   = S_WAIT;
               lat_cnt_d = 4'd1;
            end
         end
         S_WAIT: begin
            lat_cnt_d = lat_cnt_q + 4'd1;
            if (lat_cnt_q == 4'(START_LAT)) begin
               state_d   = S_CAPTURE;
               cap_cnt_d = '0;
            end
         end
         S_CAPTURE: begin
            cap_en = 1'b1;
            if (cap_cnt_q == 3'd6) begin
               state_d   = S_DRAIN;
               row_idx_d = '0;
            end else begin
               cap_cnt_d = cap_cnt_q + 3'd1;
            end
         end
         S_DRAIN: begin
            if (io.out_ready) begin
               row_idx_d = row_idx_q + 2'd1;
               if (row_idx_q == 2'd3)
                  state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---- stage p0: register the four mesh lanes every cycle ----
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < 4; j++)
            lane_p0[j] <= '0;
      end else begin
         lane_p0[0] <= io.in_c_0;
         lane_p0[1] <= io.in_c_1;
         lane_p0[2] <= io.in_c_2;
         lane_p0[3] <= io.in_c_3;
      end
   end

   // ---- capture: at step c, lane j holds its sample c-j (deskew) ----
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
               tile_q[k][j] <= '0;
      end else begin
         for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
               if (cap_en && (int'(cap_cnt_q) == j + k))
                  tile_q[k][j] <= lane_p0[j];
      end
   end

   // ---- output mux: rows read straight from the buffer, zero when idle ----
   assign drain        = (state_q == S_DRAIN);
   assign io.out_valid = drain;
   assign io.out_row   = drain ? row_idx_q : 2'd0;
   assign io.out_last  = drain && (row_idx_q == 2'd3);
   assign io.out_c_0   = drain ? relu_clamp(tile_q[row_idx_q][0]) : '0;
   assign io.out_c_1   = drain ? relu_clamp(tile_q[row_idx_q][1]) : '0;
   assign io.out_c_2   = drain ? relu_clamp(tile_q[row_idx_q][2]) : '0;
   assign io.out_c_3   = drain ? relu_clamp(tile_q[row_idx_q][3]) : '0;
   assign io.busy      = (state_q != S_IDLE);
   assign io.overrun   = overrun_q;

endmodule

// File: doc/mesh_result_collector.md
Name: mesh_result_collector

Overview:
- Reads the skewed result stream that the 4x4 Mesh drives on io_out_c_0_0..io_out_c_3_0 after a propagate sweep.
- Lane j presents its k-th result one cycle later than lane j-1 presented its own k-th result.
- Captures one full 4x4 result tile, removes the skew, and streams the tile out as four aligned rows over a valid/ready handshake toward the writeback path.

Parameters:
- WIDTH, 16, bit width of each result element (matches Mesh io_out_c).
- START_LAT, 1, cycles from the sampled start strobe to lane 0 sample 0; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_start  in  1  one-cycle strobe; a tile begins (issued with the column-0 propagate rise).
- in_c_0  in  WIDTH  Mesh io_out_c_0_0.
- in_c_1  in  WIDTH  Mesh io_out_c_1_0.
- in_c_2  in  WIDTH  Mesh io_out_c_2_0.
- in_c_3  in  WIDTH  Mesh io_out_c_3_0.
- out_valid  out  1  a deskewed row is presented.
- out_ready  in  1  the consumer accepts the row.
- out_c_0..out_c_3  out  WIDTH each  row elements; column j comes from lane j.
- out_row  out  2  index of the presented row, 0..3.
- out_last  out  1  high with row 3.
- busy  out  1  state is not IDLE.
- overrun  out  1  sticky flag: a start was dropped.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all counters 0; 16-entry tile buffer cleared.
  - out_valid, out_last, busy, overrun all 0; out_row=0; out_c_* = 0.
- Timing: in_start sampled at edge E0. Lane j sample k is sampled at edge E0+START_LAT+j+k, for j,k in 0..3.
- States:
  - IDLE: in_start=1 -> WAIT with lat_cnt=1.
  - WAIT: lat_cnt increments each cycle. When lat_cnt==START_LAT -> CAPTURE, cap_cnt=0. With START_LAT=1, the first CAPTURE edge is E0+1.
  - CAPTURE: at cap_cnt=c, every lane j with 0<=c-j<=3 writes buf[c-j][j]. cap_cnt runs 0..6; after the c=6 edge -> DRAIN with row_idx=0.
  - DRAIN: out_valid=1, out_c_j=buf[row_idx][j], out_row=row_idx, out_last=(row_idx==3).
    - On out_valid & out_ready: row_idx increments. If row_idx was 3 -> IDLE.
    - While out_ready=0, all outputs hold stable.
- out_c_* read 0 whenever out_valid=0.
- Capture takes 7 cycles regardless of out_ready; the mesh cannot be stalled.
- in_start while busy=1 (any state other than IDLE, including the cycle the last row is accepted): the start is dropped, overrun is set, and the current tile is unaffected. Only reset clears overrun.
- Elements are stored and emitted verbatim (two's-complement, no width change), except as stated under Optional Feature.
- Deassertion of reset_n mid-tile: the tile is discarded; the block restarts in IDLE on the next start.
- Latency from in_start to the first out_valid, with out_ready=1: START_LAT+7 cycles. The tile completes 4 cycles later.

Optional Feature:
- Macro: RESULT_RELU_EN.
- Defined: any element whose MSB is 1 (negative) is replaced with 0 at the output mux. The buffer still holds the raw value.
- Undefined: elements pass unmodified; no extra logic is built.

Test Plan:
- Basic tile: START_LAT=1, lane j sample k = 16*j+k, out_ready=1.
  - out_valid rises 8 cycles after start.
  - Rows are {0,16,32,48}, {1,17,33,49}, {2,18,34,50}, {3,19,35,51}.
  - out_last is high on row 3 only; busy falls the cycle after the row 3 handshake.
- Backpressure: hold out_ready=0 for 5 cycles on row 1, then assert it.
  - Row 1 values and out_row=1 stay stable throughout; no row is lost or duplicated.
- Dropped start: pulse in_start during CAPTURE and again in the cycle row 3 is accepted.
  - overrun=1 and stays 1; the first tile is correct; no second tile appears.
- Latency: START_LAT=3, same data as the basic tile.
  - out_valid first high 10 cycles after start; data identical to the basic tile.
- Async reset: assert reset_n=0 mid-DRAIN between clock edges.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - A following start captures a fresh tile correctly.
- RELU: with RESULT_RELU_EN defined, lane 2 sample 1 = 16'hFFFE (-2).
  - Row 1 column 2 reads 0; the other elements are unchanged.
  - With the macro undefined, the same element reads 16'hFFFE.
